hazard_unit_sb: RTL and testbench
=================================

// Module: hazard_unit_sb
// PURPOSE
//  Next-gen hazard unit for the 5-stage RISC-V pipeline with an attached multi-cycle MUL/DIV unit (MDU).
//  Keeps EX forwarding, load-use stall and branch flush; adds a per-register pending-write scoreboard for MDU results,
//  MDU outstanding-op limiting, an MDU-writeback forward path, a stall-cycle counter and a stall watchdog.
// PARAMETERS
//  REG_AW     5   register address width; NUM_REGS = 2**REG_AW
//  MDU_OUT    2   max MDU ops in flight (1..7)
//  WDOG_LIM   64  consecutive scoreboard-stall cycles before HazardErr
//  CNT_W      32  width of StallCount
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high
//  Rs1D/Rs2D    in   REG_AW  D-stage sources
//  RdD          in   REG_AW  D-stage destination
//  MduOpD       in   1       D-stage instr is an MDU op
//  Rs1E/Rs2E/RdE in  REG_AW  E-stage regs
//  ResultSrcE   in   1       E-stage instr is a load
//  PCSrcE       in   1       taken branch/jump resolved in E
//  MduIssueE    in   1       MDU op in E issues this cycle (dest RdE)
//  RdM, RegWriteM in REG_AW,1 M-stage write
//  RdW, RegWriteW in REG_AW,1 W-stage write
//  MduDoneW     in   1       MDU writes result via 2nd RF port this cycle
//  MduRdW       in   REG_AW  MDU result destination
//  StallF/StallD out 1       hold F / D
//  FlushD/FlushE out 1       bubble D / E
//  ForwardAE/BE out  2       00 RF, 10 M, 01 W, 11 MDU result
//  StallCount   out  CNT_W   saturating count of cycles with StallD=1
//  HazardErr    out  1       sticky: watchdog expiry or MduDoneW with nothing pending
// BEHAVIOUR
//  Reset (sync, also mid-operation): scoreboard=0, mdu_cnt=0, StallCount=0, wdog=0, HazardErr=0; in-flight MDU ops forgotten.
//  Forwarding (comb, per operand independently, RsXE!=0 required): M (RegWriteM & RdM==RsXE) > MDU (MduDoneW & MduRdW==RsXE)
//   > W (RegWriteW & RdW==RsXE) > 00.
//  lwStall = ResultSrcE & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
//  pend(r) = sb[r] | (MduIssueE & RdE==r), r!=0; sbStall = pend(Rs1D) | pend(Rs2D) | pend(RdD) (RAW + WAW).
//  fullStall = MduOpD & (mdu_cnt + MduIssueE - MduDoneW) >= MDU_OUT.
//  stall = lwStall | sbStall | fullStall. All stall terms derived from registered state; no same-cycle clear bypass.
//  PCSrcE=1: FlushD=1, FlushE=1, StallF=StallD=0 (branch overrides stall; D instr is discarded).
//  Else: StallF=StallD=stall, FlushD=0, FlushE=stall.
//  Scoreboard update @posedge: MduIssueE & RdE!=0 sets sb[RdE]; MduDoneW clears sb[MduRdW]; same index set+clear -> set wins.
//  mdu_cnt: +1 on MduIssueE, -1 on MduDoneW, both -> unchanged. MduDoneW with mdu_cnt==0 (no simultaneous issue) -> HazardErr,
//   mdu_cnt held at 0. Never exceeds MDU_OUT by construction; issue at MDU_OUT -> HazardErr, count saturates.
//  StallCount: +1 each cycle StallD=1, saturates at all-ones.
//  Watchdog: wdog +1 each cycle sbStall=1 & PCSrcE=0, else cleared; wdog==WDOG_LIM -> HazardErr (sticky until reset).
//  Latency: all control outputs combinational from inputs + registered state; scoreboard visible the cycle after update.
// STRUCTURE
//  Shared pkg hazard_pkg: FWD_RF/FWD_W/FWD_M/FWD_MDU 2-bit constants, REG_AW default.
//  One sub-module: mdu_scoreboard (sb vector, mdu_cnt, set/clear, pend lookups x3, full flag); hazard_unit_sb adds forwarding,
//   stall/flush priority, StallCount, watchdog.
// TESTING
//  1 add x5 in M, Rs1E=5, also RegWriteW RdW=5 -> ForwardAE=10; RdM=0 with Rs1E=0 -> 00.
//  2 lw x7 in E (ResultSrcE=1,RdE=7), Rs2D=7 -> StallF=StallD=FlushE=1 one cycle, StallCount=1.
//  3 MduIssueE RdE=9; next 5 cycles Rs1D=9 -> StallD=1; MduDoneW MduRdW=9 -> Rs1E=9 gets 11 that cycle, StallD=0 following cycle.
//  4 MDU_OUT=2: two issues, third MduOpD -> fullStall until one MduDoneW; PCSrcE during stall -> FlushD=FlushE=1, StallD=0.
//  5 pending x3, no MduDoneW for 64 stall cycles -> HazardErr=1, stays 1; reset -> all state 0; MduDoneW idle -> HazardErr=1.
//  6 same-cycle MduIssueE RdE=4 and MduDoneW MduRdW=4 -> sb[4]=1, mdu_cnt unchanged.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard unit: forwarding selects and default widths.
package hazard_pkg;
    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned MDU_CNT_W  = 4;   // holds MDU_OUT (<=7) plus one issue

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;
    localparam logic [1:0] FWD_MDU = 2'b11;
endpackage

// File: rtl/mdu_scoreboard.sv
// Pending-write scoreboard for MDU destinations plus the in-flight op counter.
module mdu_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW  = REG_AW_DEF,
    parameter int unsigned MDU_OUT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              done,
    input  logic [REG_AW-1:0] done_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic              mdu_op,
    output logic              pend_rs1,
    output logic              pend_rs2,
    output logic              pend_rd,
    output logic              full,
    output logic              cnt_err
);
    localparam int unsigned NUM_REGS = 1 << REG_AW;

    logic [NUM_REGS-1:0]  sb;
    logic [NUM_REGS-1:0]  sb_next;
    logic [MDU_CNT_W-1:0] cnt;
    logic [MDU_CNT_W-1:0] eff;

    // An op issuing this cycle already counts as pending for D-stage lookups.
    function automatic logic pend_of(input logic [NUM_REGS-1:0] vec,
                                     input logic iss,
                                     input logic [REG_AW-1:0] iss_rd,
                                     input logic [REG_AW-1:0] r);
        return (r != '0) && (vec[r] || (iss && (iss_rd == r)));
    endfunction

    always_comb begin
        pend_rs1 = pend_of(sb, issue, issue_rd, rs1);
        pend_rs2 = pend_of(sb, issue, issue_rd, rs2);
        pend_rd  = pend_of(sb, issue, issue_rd, rd);
    end

    // (cnt + issue - done) >= MDU_OUT, rearranged to stay unsigned
    always_comb begin
        eff  = cnt + MDU_CNT_W'(issue);
        full = mdu_op && (eff >= (MDU_CNT_W'(MDU_OUT) + MDU_CNT_W'(done)));
    end

    always_comb begin
        cnt_err = (issue && !done && (cnt == MDU_CNT_W'(MDU_OUT))) ||
                  (done && !issue && (cnt == '0));
    end

    // Clear first so a same-index issue in the same cycle wins.
    always_comb begin
        sb_next = sb;
        if (done) begin
            sb_next[done_rd] = 1'b0;
        end
        if (issue && (issue_rd != '0)) begin
            sb_next[issue_rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb  <= '0;
            cnt <= '0;
        end else begin
            sb <= sb_next;
            if (issue && !done && (cnt != MDU_CNT_W'(MDU_OUT))) begin
                cnt <= cnt + 1'b1;
            end else if (done && !issue && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: rtl/hazard_unit_sb.sv
// Pipeline hazard unit: forwarding, load-use / MDU scoreboard stalls, branch flush,
// stall-cycle counter and scoreboard-stall watchdog.
module hazard_unit_sb
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned MDU_OUT  = 2,
    parameter int unsigned WDOG_LIM = 64,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              MduOpD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              ResultSrcE,
    input  logic              PCSrcE,
    input  logic              MduIssueE,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteW,
    input  logic              MduDoneW,
    input  logic [REG_AW-1:0] MduRdW,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [CNT_W-1:0]  StallCount,
    output logic              HazardErr
);
    localparam int unsigned WD_W = $clog2(WDOG_LIM + 1);

    logic pend_rs1, pend_rs2, pend_rd, full_stall, cnt_err;
    logic lw_stall, sb_stall, stall;
    logic [WD_W-1:0] wdog, wdog_next;

    mdu_scoreboard #(
        .REG_AW  (REG_AW),
        .MDU_OUT (MDU_OUT)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .issue    (MduIssueE),
        .issue_rd (RdE),
        .done     (MduDoneW),
        .done_rd  (MduRdW),
        .rs1      (Rs1D),
        .rs2      (Rs2D),
        .rd       (RdD),
        .mdu_op   (MduOpD),
        .pend_rs1 (pend_rs1),
        .pend_rs2 (pend_rs2),
        .pend_rd  (pend_rd),
        .full     (full_stall),
        .cnt_err  (cnt_err)
    );

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input logic wm, input logic [REG_AW-1:0] rdm,
                                           input logic md, input logic [REG_AW-1:0] mrd,
                                           input logic ww, input logic [REG_AW-1:0] rdw);
        if (rs == '0)               return FWD_RF;
        if (wm && (rdm == rs))      return FWD_M;
        if (md && (mrd == rs))      return FWD_MDU;
        if (ww && (rdw == rs))      return FWD_W;
        return FWD_RF;
    endfunction

    always_comb begin
        ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, MduDoneW, MduRdW, RegWriteW, RdW);
        ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, MduDoneW, MduRdW, RegWriteW, RdW);
    end

    always_comb begin
        lw_stall = ResultSrcE && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
        sb_stall = pend_rs1 || pend_rs2 || pend_rd;
        stall    = lw_stall || sb_stall || full_stall;
    end

    // A taken branch discards the D instruction, so it overrides any stall.
    always_comb begin
        if (PCSrcE) begin
            StallF = 1'b0;
            StallD = 1'b0;
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            StallF = stall;
            StallD = stall;
            FlushD = 1'b0;
            FlushE = stall;
        end
    end

    always_comb begin
        wdog_next = '0;
        if (sb_stall && !PCSrcE) begin
            wdog_next = (wdog == WD_W'(WDOG_LIM)) ? wdog : wdog + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount <= '0;
            wdog       <= '0;
            HazardErr  <= 1'b0;
        end else begin
            if (StallD && (StallCount != '1)) begin
                StallCount <= StallCount + 1'b1;
            end
            wdog <= wdog_next;
            if (cnt_err || (wdog_next == WD_W'(WDOG_LIM))) begin
                HazardErr <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_unit_sb.sv
// Bench for hazard_unit_sb: combinational vector table, directed multi-cycle
// sequences, then randomized traffic against a behavioural model.
module tb_hazard_unit_sb;
    localparam int MDU_OUT  = 2;
    localparam int WDOG_LIM = 64;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, MduRdW;
    logic MduOpD, ResultSrcE, PCSrcE, MduIssueE, RegWriteM, RegWriteW, MduDoneW;
    logic StallF, StallD, FlushD, FlushE, HazardErr;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCount;

    int ntot = 0;
    int npass = 0;

    always #5 clk = ~clk;

    hazard_unit_sb #(
        .REG_AW   (5),
        .MDU_OUT  (MDU_OUT),
        .WDOG_LIM (WDOG_LIM),
        .CNT_W    (CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .MduOpD(MduOpD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .MduIssueE(MduIssueE),
        .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
        .MduDoneW(MduDoneW), .MduRdW(MduRdW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallCount(StallCount), .HazardErr(HazardErr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; RdD = 0; MduOpD = 0;
        Rs1E = 0; Rs2E = 0; RdE = 0; ResultSrcE = 0; PCSrcE = 0; MduIssueE = 0;
        RdM = 0; RegWriteM = 0; RdW = 0; RegWriteW = 0; MduDoneW = 0; MduRdW = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string name, input logic sd, input logic fd, input logic fe);
        chk({name, " StallF"}, 32'(StallF), 32'(sd));
        chk({name, " StallD"}, 32'(StallD), 32'(sd));
        chk({name, " FlushD"}, 32'(FlushD), 32'(fd));
        chk({name, " FlushE"}, 32'(FlushE), 32'(fe));
    endtask

    typedef struct {
        logic [4:0] rs1e, rs2e, rdm, rdw, mrdw, rs1d, rs2d, rdd, rde;
        logic wm, ww, mdone, ldE, pc, iss, mop;
        logic [1:0] fa, fb;
        logic sd, fd, fe;
    } vec_t;

    // Behavioural model state
    bit mpend[32];
    int mcnt, mscnt, mwdog;
    bit merr;
    int inflight[$];

    task automatic model_reset();
        foreach (mpend[i]) mpend[i] = 0;
        mcnt = 0; mscnt = 0; mwdog = 0; merr = 0;
        inflight.delete();
    endtask

    function automatic int ref_fwd(int rs);
        if (rs == 0) return 0;
        if (RegWriteM && int'(RdM) == rs) return 2;
        if (MduDoneW && int'(MduRdW) == rs) return 3;
        if (RegWriteW && int'(RdW) == rs) return 1;
        return 0;
    endfunction

    function automatic bit ref_pend(int r);
        return r != 0 && (mpend[r] || (MduIssueE && int'(RdE) == r));
    endfunction

    initial begin
        vec_t tbl[12];
        bit lw, sbs, fulls, st, sdx;
        int ncyc;

        reset = 1; idle();
        tick(); tick();
        chk("reset StallCount", 32'(StallCount), 0);
        chk("reset HazardErr", 32'(HazardErr), 0);
        chk_ctl("reset", 0, 0, 0);

        // Applied while reset is held, so every vector sees empty state.
        //          rs1e rs2e rdm rdw mrdw rs1d rs2d rdd rde wm ww md ld pc is mop fa fb sd fd fe
        tbl[0]  = '{5, 0, 5, 5, 0,  0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        tbl[2]  = '{3, 3, 1, 3, 0,  0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0};
        tbl[3]  = '{6, 6, 6, 6, 6,  0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 2'b11, 2'b11, 0, 0, 0};
        tbl[4]  = '{6, 8, 8, 6, 6,  0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 2'b11, 2'b10, 0, 0, 0};
        tbl[5]  = '{8, 8, 8, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0,  0, 7, 0, 7,  0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1};
        tbl[7]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0,  7, 0, 0, 7,  0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1};
        tbl[9]  = '{0, 0, 0, 0, 0,  7, 0, 0, 7,  0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0,  4, 0, 0, 4,  0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 1};
        tbl[11] = '{0, 0, 0, 0, 0,  0, 0, 4, 4,  0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 1, 0, 1};
        for (int i = 0; i < 12; i++) begin
            Rs1E = tbl[i].rs1e; Rs2E = tbl[i].rs2e; RdM = tbl[i].rdm; RdW = tbl[i].rdw;
            MduRdW = tbl[i].mrdw; Rs1D = tbl[i].rs1d; Rs2D = tbl[i].rs2d; RdD = tbl[i].rdd;
            RdE = tbl[i].rde; RegWriteM = tbl[i].wm; RegWriteW = tbl[i].ww;
            MduDoneW = tbl[i].mdone; ResultSrcE = tbl[i].ldE; PCSrcE = tbl[i].pc;
            MduIssueE = tbl[i].iss; MduOpD = tbl[i].mop;
            #2;
            chk($sformatf("tbl%0d ForwardAE", i), 32'(ForwardAE), 32'(tbl[i].fa));
            chk($sformatf("tbl%0d ForwardBE", i), 32'(ForwardBE), 32'(tbl[i].fb));
            chk_ctl($sformatf("tbl%0d", i), tbl[i].sd, tbl[i].fd, tbl[i].fe);
            tick();
        end

        // Load-use stall for exactly one cycle
        idle(); tick();
        reset = 0;
        ResultSrcE = 1; RdE = 7; Rs2D = 7;
        #2; chk_ctl("lwuse", 1, 0, 1);
        tick(); idle(); #2;
        chk_ctl("lwuse after", 0, 0, 0);
        chk("lwuse StallCount", 32'(StallCount), 1);

        // MDU RAW on x9: stall while pending, MDU forward on completion
        tick();
        MduIssueE = 1; RdE = 9; tick(); idle();
        for (int i = 0; i < 5; i++) begin
            Rs1D = 9; #2;
            chk($sformatf("raw9 c%0d StallD", i), 32'(StallD), 1);
            tick();
        end
        Rs1D = 9; MduDoneW = 1; MduRdW = 9; Rs1E = 9; #2;
        chk("raw9 done ForwardAE", 32'(ForwardAE), 3);
        chk("raw9 done StallD", 32'(StallD), 1);
        tick(); idle(); Rs1D = 9; #2;
        chk("raw9 cleared StallD", 32'(StallD), 0);
        chk("raw9 StallCount", 32'(StallCount), 7);
        tick(); idle();

        // Outstanding-op limit, branch override, release on completion
        MduIssueE = 1; RdE = 10; tick();
        RdE = 11; tick(); idle();
        MduOpD = 1; RdD = 12;
        for (int i = 0; i < 2; i++) begin
            #2; chk_ctl($sformatf("full c%0d", i), 1, 0, 1); tick();
        end
        PCSrcE = 1; #2; chk_ctl("full branch", 0, 1, 1); tick();
        PCSrcE = 0; MduDoneW = 1; MduRdW = 10; #2;
        chk_ctl("full done", 0, 0, 0); tick();
        MduDoneW = 0; #2; chk_ctl("full cnt1", 0, 0, 0); tick();
        idle(); MduDoneW = 1; MduRdW = 11; tick(); idle(); #2;
        chk("full HazardErr", 32'(HazardErr), 0);

        // Watchdog: 63 stall cycles are tolerated, the 64th trips it
        MduIssueE = 1; RdE = 3; tick(); idle();
        Rs1D = 3;
        for (int i = 0; i < WDOG_LIM - 1; i++) tick();
        #2; chk("wdog 63 HazardErr", 32'(HazardErr), 0);
        tick(); #2; chk("wdog 64 HazardErr", 32'(HazardErr), 1);
        idle(); MduDoneW = 1; MduRdW = 3; tick(); idle();
        tick(); tick(); #2;
        chk("wdog sticky HazardErr", 32'(HazardErr), 1);
        reset = 1; tick(); reset = 0; #2;
        chk("rst HazardErr", 32'(HazardErr), 0);
        chk("rst StallCount", 32'(StallCount), 0);
        MduDoneW = 1; MduRdW = 5; tick(); idle(); #2;
        chk("underflow HazardErr", 32'(HazardErr), 1);
        reset = 1; tick(); reset = 0;

        // Same-cycle issue/complete on x4: bit stays set, count unchanged
        MduIssueE = 1; RdE = 4; MduDoneW = 1; MduRdW = 4; tick(); idle();
        Rs1D = 4; #2; chk("setclr StallD", 32'(StallD), 1);
        chk("setclr HazardErr", 32'(HazardErr), 0);
        idle(); MduIssueE = 1; RdE = 20; tick(); RdE = 21; tick(); idle();
        MduOpD = 1; #2; chk("setclr cnt2 StallD", 32'(StallD), 1);
        chk("setclr cnt2 HazardErr", 32'(HazardErr), 0);
        idle(); MduIssueE = 1; RdE = 22; tick(); idle(); #2;
        chk("overflow HazardErr", 32'(HazardErr), 1);
        reset = 1; tick(); reset = 0;

        // Randomized traffic against the behavioural model
        model_reset();
        ncyc = 0;
        repeat (3000) begin
            idle();
            reset = ($urandom_range(0, 399) == 0);
            Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
            RdD = 5'($urandom_range(0, 7)); MduOpD = $urandom_range(0, 1) == 1;
            Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
            RdE = 5'($urandom_range(0, 7));
            ResultSrcE = $urandom_range(0, 3) == 0;
            PCSrcE = $urandom_range(0, 7) == 0;
            RdM = 5'($urandom_range(0, 7)); RegWriteM = $urandom_range(0, 1) == 1;
            RdW = 5'($urandom_range(0, 7)); RegWriteW = $urandom_range(0, 1) == 1;
            MduIssueE = (inflight.size() < MDU_OUT) && ($urandom_range(0, 3) == 0);
            MduDoneW = (inflight.size() > 0) && ($urandom_range(0, 3) == 0);
            MduRdW = MduDoneW ? 5'(inflight[0]) : 5'($urandom_range(0, 7));
            if (!MduDoneW && $urandom_range(0, 499) == 0) MduDoneW = 1;

            lw = ResultSrcE && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
            sbs = ref_pend(int'(Rs1D)) || ref_pend(int'(Rs2D)) || ref_pend(int'(RdD));
            fulls = MduOpD && (mcnt + int'(MduIssueE) - int'(MduDoneW) >= MDU_OUT);
            st = lw || sbs || fulls;
            sdx = !PCSrcE && st;
            #2;
            chk($sformatf("rnd%0d ForwardAE", ncyc), 32'(ForwardAE), 32'(ref_fwd(int'(Rs1E))));
            chk($sformatf("rnd%0d ForwardBE", ncyc), 32'(ForwardBE), 32'(ref_fwd(int'(Rs2E))));
            chk_ctl($sformatf("rnd%0d", ncyc), sdx, PCSrcE, PCSrcE || st);
            chk($sformatf("rnd%0d StallCount", ncyc), 32'(StallCount), 32'(mscnt));
            chk($sformatf("rnd%0d HazardErr", ncyc), 32'(HazardErr), 32'(merr));

            if (reset) begin
                model_reset();
            end else begin
                if (sdx && mscnt < CNT_MAX) mscnt++;
                if (sbs && !PCSrcE) begin
                    mwdog++;
                    if (mwdog >= WDOG_LIM) merr = 1;
                end else begin
                    mwdog = 0;
                end
                if (MduIssueE && !MduDoneW) begin
                    if (mcnt == MDU_OUT) merr = 1; else mcnt++;
                end else if (MduDoneW && !MduIssueE) begin
                    if (mcnt == 0) merr = 1; else mcnt--;
                end
                if (MduDoneW) begin
                    mpend[MduRdW] = 0;
                    if (inflight.size() > 0) void'(inflight.pop_front());
                end
                if (MduIssueE) begin
                    if (RdE != 0) mpend[RdE] = 1;
                    inflight.push_back(int'(RdE));
                end
            end
            tick();
            ncyc++;
        end
        reset = 0;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
